// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency SRAM port between instruction fetch and the MEM stage.
// Data accesses win arbitration; a small FSM sequences each transfer and pulses ready.
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    output logic              if_stall,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              mem_stall,
    output logic [ADDR_W-3:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    output logic              sram_we,
    output logic              sram_oe,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DATA} owner_t;
    typedef enum logic {OP_RD, OP_WR} op_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t            state_q;
    owner_t            owner_q;
    op_t               op_q;
    logic [3:0]        cnt_q;
    logic [3:0]        cnt_d;
    logic [ADDR_W-3:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;
    logic              oe_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] mem_rdata_q;
    logic              if_ready_q;
    logic              mem_ready_q;
    logic              data_req;
    logic              unused_addr_bits;

    assign data_req         = mem_rd | mem_wr;
    assign cnt_d            = cnt_q - 4'd1;
    assign unused_addr_bits = ^{if_addr[1:0], mem_addr[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_NONE;
            op_q        <= OP_RD;
            cnt_q       <= 4'd0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            oe_q        <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (data_req) begin
                        // A simultaneous rd+wr is carried out as a write.
                        owner_q <= OWN_DATA;
                        op_q    <= mem_wr ? OP_WR : OP_RD;
                        addr_q  <= mem_addr[ADDR_W-1:2];
                        wdata_q <= mem_wdata;
                        we_q    <= mem_wr;
                        oe_q    <= ~mem_wr;
                        cnt_q   <= CNT_INIT;
                        state_q <= ACCESS;
                    end else if (if_req) begin
                        owner_q <= OWN_IF;
                        op_q    <= OP_RD;
                        addr_q  <= if_addr[ADDR_W-1:2];
                        we_q    <= 1'b0;
                        oe_q    <= 1'b1;
                        cnt_q   <= CNT_INIT;
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt_q == 4'd0) begin
                        we_q <= 1'b0;
                        oe_q <= 1'b0;
                        if (op_q == OP_RD) begin
                            if (owner_q == OWN_DATA)
                                mem_rdata_q <= sram_rdata;
                            else if (owner_q == OWN_IF)
                                if_rdata_q <= sram_rdata;
                        end
                        mem_ready_q <= (owner_q == OWN_DATA);
                        if_ready_q  <= (owner_q == OWN_IF);
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                DONE: begin
                    // No grant here, so a request still held during its ready is not re-served.
                    mem_ready_q <= 1'b0;
                    if_ready_q  <= 1'b0;
                    owner_q     <= OWN_NONE;
                    state_q     <= IDLE;
                end
                default: begin
                    we_q    <= 1'b0;
                    oe_q    <= 1'b0;
                    owner_q <= OWN_NONE;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;
    assign sram_we    = we_q;
    assign sram_oe    = oe_q;
    assign if_rdata   = if_rdata_q;
    assign mem_rdata  = mem_rdata_q;
    assign if_ready   = if_ready_q;
    assign mem_ready  = mem_ready_q;
    assign busy       = (state_q != IDLE);
    assign if_stall   = if_req & ~if_ready_q;
    assign mem_stall  = data_req & ~mem_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural SRAM and read-data scoreboard.
module tb_mem_port_arbiter;

    localparam int WAIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        if_stall;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        mem_stall;
    logic [29:0] sram_addr;
    logic [31:0] sram_wdata;
    logic        sram_we;
    logic        sram_oe;
    logic [31:0] sram_rdata;
    logic        busy;

    logic        pl_en;
    logic [7:0]  pl_addr;
    logic [31:0] pl_data;
    logic [31:0] sram_mem [256];

    logic [31:0] if_q[$];
    logic [31:0] mem_q[$];
    int          n_assert = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(WAIT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_ready(if_ready), .if_stall(if_stall),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .mem_stall(mem_stall),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_we(sram_we), .sram_oe(sram_oe), .sram_rdata(sram_rdata),
        .busy(busy)
    );

    // Behavioural SRAM: preload port plus the DUT write strobe
    always @(posedge clk) begin
        if (pl_en) sram_mem[pl_addr] <= pl_data;
        if (sram_we) sram_mem[sram_addr[7:0]] <= sram_wdata;
    end
    assign sram_rdata = sram_oe ? sram_mem[sram_addr[7:0]] : 32'h0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_check(input string tag, input bit is_if);
        logic [31:0] e;
        if (is_if ? (if_q.size() == 0) : (mem_q.size() == 0)) begin
            check({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = is_if ? if_q.pop_front() : mem_q.pop_front();
            check({tag, "_rdata"}, is_if ? if_rdata : mem_rdata, e);
        end
    endtask

    // Runs one transfer already requested by the caller; checks strobes, latency and data.
    task automatic run_access(input string tag, input bit is_if, input bit is_wr,
                              input logic [29:0] exp_waddr, input logic [31:0] exp_wdata);
        int lat = 0;
        int strobes = 0;
        bit seen = 0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            tick();
            if (sram_oe || sram_we) begin
                strobes++;
                check({tag, "_addr"}, sram_addr, exp_waddr);
                check({tag, "_we"}, sram_we, is_wr);
                check({tag, "_oe"}, sram_oe, !is_wr);
                if (is_wr) check({tag, "_wdata"}, sram_wdata, exp_wdata);
            end
            if (is_if ? if_ready : mem_ready) begin
                seen = 1;
                lat = k;
            end
        end
        check({tag, "_ready_seen"}, seen, 1);
        check({tag, "_latency"}, lat, WAIT + 1);
        check({tag, "_strobes"}, strobes, WAIT);
        if (seen) begin
            check({tag, "_stall_at_ready"}, is_if ? if_stall : mem_stall, 0);
            check({tag, "_busy_done"}, busy, 1);
            if (!is_wr) pop_check(tag, is_if);
        end
    endtask

    initial begin
        int t1, t2, npulse, oe_cnt, mem_t, if_t, if_acc_t;
        rst = 1'b1; if_req = 0; if_addr = 0; mem_rd = 0; mem_wr = 0;
        mem_addr = 0; mem_wdata = 0; pl_en = 0; pl_addr = 0; pl_data = 0;

        #1;
        check("rst_if_rdata", if_rdata, 0);
        check("rst_mem_rdata", mem_rdata, 0);
        check("rst_ready", {if_ready, mem_ready}, 0);
        check("rst_sram", {sram_we, sram_oe, sram_addr, sram_wdata}, 0);
        check("rst_busy", busy, 0);
        if_req = 1; #1;
        check("rst_if_stall_follows", if_stall, 1);
        check("rst_mem_stall_idle", mem_stall, 0);
        if_req = 0; mem_wr = 1; #1;
        check("rst_mem_stall_follows", mem_stall, 1);
        mem_wr = 0;

        // Preload SRAM while held in reset
        pl_en = 1; pl_addr = 8'd4; pl_data = 32'hE3A0_1005; tick();
        pl_addr = 8'd8; pl_data = 32'h1111_2222; tick();
        pl_addr = 8'd9; pl_data = 32'h3333_4444; tick();
        pl_en = 0;
        rst = 0;
        tick();
        check("idle_busy", busy, 0);

        // Single fetch
        if_req = 1; if_addr = 32'h0000_0010; if_q.push_back(32'hE3A0_1005);
        run_access("fetch", 1, 0, 30'd4, 32'h0);
        if_req = 0;
        tick();
        check("fetch_idle", busy, 0);

        // Store then load
        mem_wr = 1; mem_addr = 32'h100; mem_wdata = 32'hDEAD_BEEF;
        run_access("store", 0, 1, 30'h40, 32'hDEAD_BEEF);
        check("store_keeps_mem_rdata", mem_rdata, 0);
        mem_wr = 0;
        tick();
        mem_rd = 1; mem_q.push_back(32'hDEAD_BEEF);
        run_access("load", 0, 0, 30'h40, 32'h0);
        mem_rd = 0;
        tick();

        // Contention: both requests on the same edge
        mem_rd = 1; mem_addr = 32'h20; mem_q.push_back(32'h1111_2222);
        if_req = 1; if_addr = 32'h24; if_q.push_back(32'h3333_4444);
        mem_t = 0; if_t = 0; if_acc_t = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (mem_ready) begin
                mem_t = k;
                pop_check("cont_mem", 0);
                mem_rd = 0;
            end
            if (sram_oe && sram_addr == 30'd9 && if_acc_t == 0) if_acc_t = k;
            if (k == 6) check("cont_idle_gap", busy, 0);
            if (if_ready) begin
                if_t = k;
                check("cont_if_stall_ready", if_stall, 0);
                pop_check("cont_if", 1);
                if_req = 0;
                break;
            end else begin
                check("cont_if_stall", if_stall, 1);
            end
        end
        check("cont_mem_ready_t", mem_t, 5);
        check("cont_if_access_t", if_acc_t, 7);
        check("cont_if_ready_t", if_t, 11);
        tick();

        // Held fetch request
        if_req = 1; if_addr = 32'h10;
        if_q.push_back(32'hE3A0_1005); if_q.push_back(32'hE3A0_1005);
        npulse = 0; t1 = 0; t2 = 0;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (k == 12) if_req = 0;
            if (if_ready) begin
                npulse++;
                if (npulse == 1) t1 = k; else t2 = k;
                pop_check("held", 1);
            end
        end
        check("held_pulses", npulse, 2);
        check("held_spacing", t2 - t1, 6);
        check("held_idle", busy, 0);

        // Fetch flushed on the second ACCESS cycle
        if_req = 1; if_addr = 32'h24; if_q.push_back(32'h3333_4444);
        npulse = 0; oe_cnt = 0; t1 = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 2) if_req = 0;
            if (sram_oe) oe_cnt++;
            if (if_ready) begin
                npulse++;
                t1 = k;
                pop_check("flush", 1);
            end
        end
        check("flush_oe_cycles", oe_cnt, WAIT);
        check("flush_pulses", npulse, 1);
        check("flush_ready_t", t1, 5);
        check("flush_idle", busy, 0);
        check("flush_stall", if_stall, 0);

        // Asynchronous reset during the third ACCESS cycle of a write
        mem_wr = 1; mem_addr = 32'h200; mem_wdata = 32'hCAFE_F00D;
        tick(); tick(); tick();
        check("rstw_we_before", sram_we, 1);
        #2 rst = 1;
        #1;
        check("rstw_we_now", sram_we, 0);
        check("rstw_rdata", {if_rdata, mem_rdata}, 0);
        check("rstw_sram", {sram_oe, sram_addr, sram_wdata}, 0);
        check("rstw_ready_busy", {if_ready, mem_ready, busy}, 0);
        check("rstw_mem_stall", mem_stall, 1);
        mem_wr = 0;
        tick();
        rst = 0;
        tick();
        if_req = 1; if_addr = 32'h10; if_q.push_back(32'hE3A0_1005);
        run_access("post_rst_fetch", 1, 0, 30'd4, 32'h0);
        if_req = 0;
        tick();
        check("post_rst_idle", busy, 0);
        check("sb_drained", if_q.size() + mem_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
